gearbox_tx_32b: RTL

Transmit 66:32 gearbox for the 10GBASE-R PCS; sits directly downstream of the 32-bit TX scrambler. Takes scrambled 32-bit half-blocks plus a 2-bit sync header on even half-blocks, and packs the resulting 66-bit block stream into a continuous 32-bit PMA word stream. Generates the 32-of-33 request cadence that throttles the upstream encoder/scrambler pipeline.

---
 rtl/gearbox_tx_32b.sv | 112 +++++++++++
 1 files changed

// File: rtl/gearbox_tx_32b.sv
// gearbox_tx_32b
// Transmit 66:32 gearbox for a 10GBASE-R PCS. It accepts scrambled 32-bit
// half-blocks and prepends the 2-bit sync header on the first half of each
// 66-bit block. The resulting bit stream is repacked into a continuous
// 32-bit PMA word stream. A 33-cycle sequence counter throttles the upstream
// pipeline so that it issues 32 half-blocks in every 33 cycles.
//
// Ports:
//   clk     in   1   single clock for all logic
//   rst     in   1   synchronous, active-high reset
//   din     in  32   scrambled half-block, bit 0 transmitted first
//   ctrlin  in   2   sync header (used when evenin=1), ctrlin[0] first
//   din_en  in   1   din/ctrlin/evenin valid this cycle
//   evenin  in   1   first half of a 66-bit block (header prepended)
//   req     out  1   upstream may issue a half-block this cycle
//   dout    out 32   PMA word, bit 0 transmitted first
//   dout_en out  1   dout valid
//   ovf     out  1   sticky buffer-overflow flag
//   unf     out  1   sticky underflow flag

module gearbox_tx_32b #(
    parameter int BUF_W = 96
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] din,
    input  logic [1:0]  ctrlin,
    input  logic        din_en,
    input  logic        evenin,
    output logic        req,
    output logic [31:0] dout,
    output logic        dout_en,
    output logic        ovf,
    output logic        unf
);

    localparam logic [7:0] BUF_LIMIT = 8'(BUF_W);

    logic [5:0]       seq;
    logic [5:0]       seq_next;
    logic [BUF_W-1:0] bit_buf;
    logic [BUF_W-1:0] bit_buf_next;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    logic [6:0]       fill;
    logic [6:0]       fill_next;
    logic [6:0]       fill_after_out;
    logic [7:0]       fill_sum;
    logic [7:0]       add_w;
    logic [33:0]      add_bits;
    logic             out_fire;
    logic             accept;
    logic             drop;
    logic             started;

    // Sequence counter 0..32; the single idle slot at 32 absorbs the two
    // extra header bits carried by every 66-bit block.
    always_comb begin
        seq_next = (seq == 6'd32) ? 6'd0 : seq + 6'd1;
    end

    // Bit FIFO datapath. Bits above fill are always zero, so a new word can
    // be OR-ed in at position fill after the optional 32-bit drain. A word
    // that would not fit entirely is dropped rather than partially written.
    always_comb begin
        out_fire       = (fill >= 7'd32);
        shifted        = out_fire ? (bit_buf >> 32) : bit_buf;
        fill_after_out = out_fire ? (fill - 7'd32) : fill;
        add_bits       = evenin ? {din, ctrlin} : {2'b00, din};
        add_w          = evenin ? 8'd34 : 8'd32;
        fill_sum       = {1'b0, fill_after_out} + add_w;
        accept         = din_en && (fill_sum <= BUF_LIMIT);
        drop           = din_en && !accept;
        placed         = {{(BUF_W-34){1'b0}}, add_bits} << fill_after_out;
        bit_buf_next   = accept ? (shifted | placed) : shifted;
        fill_next      = accept ? fill_sum[6:0] : fill_after_out;
    end

    // State registers. req is registered from the next sequence value so
    // that req is low exactly while seq sits at 32. Underflow is only
    // flagged once the first word has gone out since reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            seq     <= 6'd0;
            req     <= 1'b0;
            bit_buf <= '0;
            fill    <= 7'd0;
            dout    <= 32'd0;
            dout_en <= 1'b0;
            started <= 1'b0;
            ovf     <= 1'b0;
            unf     <= 1'b0;
        end else begin
            seq     <= seq_next;
            req     <= (seq_next != 6'd32);
            bit_buf <= bit_buf_next;
            fill    <= fill_next;
            dout_en <= out_fire;
            if (out_fire) begin
                dout    <= bit_buf[31:0];
                started <= 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end
            if (started && !out_fire) begin
                unf <= 1'b1;
            end
        end
    end

endmodule
